ctrl_unit_mc: RTL

Parametrised multicycle control unit for the MIPS-subset datapath. It replaces the single-path fetch/add sequencer with a full FSM covering these instruction classes:
- R-type add/sub/and/slt
- addi
- beq/bne
- lw/sw
- j

It adds configurable memory wait states and precise exceptions for invalid opcode and arithmetic overflow. It sits beside the datapath and drives all register-enable and mux-select lines from the latched instruction and the ALU flags.

---
 rtl/ctrl_unit_mc.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_unit_mc.sv
// ---------------------------------------------------------------------------
// ctrl_unit_mc : multicycle control unit for the MIPS-subset datapath.
//
// Sequences fetch / decode / execute / memory / write-back for R-type
// add/sub/and/slt, addi, beq/bne, lw/sw and j, with configurable memory wait
// states and precise traps for invalid opcodes and arithmetic overflow.
//
// Parameters
//   MEM_WAIT   : extra memory cycles before read data is valid (0..7)
//   EXC_ENABLE : 1 = overflow / invalid opcode trap, 0 = ignored / NOP
//   EXC_VECTOR : handler address presented on ExcVector
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   Instruction_31_26                opcode from the instruction register
//   Instruction_15_0                 immediate field, funct = [5:0]
//   Overflow, Zero, LT               ALU flags (combinational, same cycle)
//   WritePC .. WriteEPC              register / memory write enables
//   memAddrCtrl                      0 PC, 1 ALUOut
//   ALUSrcACtrl                      0 PC, 1 A
//   ALUSrcBCtrl                      00 B, 01 4, 10 sext imm, 11 sext imm<<2
//   PCSrcCtrl                        00 ALU, 01 ALUOut, 10 jump, 11 ExcVector
//   WriteRegCtrl                     00 rt, 01 rd, 11 $29
//   WriteDataCtrl                    00 ALUOut, 01 MDR, 11 const 227
//   ALUCtrl                          001 add, 010 sub, 011 and, 111 compare
//   ExcVector, ExcCause, resetOut    trap address, last trap cause, in-reset
// ---------------------------------------------------------------------------
module ctrl_unit_mc #(
    parameter int unsigned MEM_WAIT   = 2,
    parameter bit          EXC_ENABLE = 1'b1,
    parameter logic [31:0] EXC_VECTOR = 32'h000000FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Instruction_31_26,
    input  logic [15:0] Instruction_15_0,
    input  logic        Overflow,
    input  logic        Zero,
    input  logic        LT,
    output logic        WritePC,
    output logic        WriteA,
    output logic        WriteB,
    output logic        WriteALUOut,
    output logic        WriteMDR,
    output logic        WriteMem,
    output logic        WriteInstruction,
    output logic        WriteReg,
    output logic        WriteEPC,
    output logic        memAddrCtrl,
    output logic        ALUSrcACtrl,
    output logic [1:0]  ALUSrcBCtrl,
    output logic [1:0]  PCSrcCtrl,
    output logic [1:0]  WriteRegCtrl,
    output logic [1:0]  WriteDataCtrl,
    output logic [2:0]  ALUCtrl,
    output logic [31:0] ExcVector,
    output logic [1:0]  ExcCause,
    output logic        resetOut
);

    localparam logic [2:0] WAIT_C = 3'(MEM_WAIT);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_BRANCH, S_JUMP, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXC
    } state_t;

    typedef struct packed {
        logic       wpc;
        logic       wa;
        logic       wb;
        logic       walu;
        logic       wmdr;
        logic       wmem;
        logic       wir;
        logic       wreg;
        logic       wepc;
        logic       maddr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] wdata;
        logic [2:0] alu;
        logic       rst_out;
    } ctrl_t;

    state_t      state_r, state_nx_s;
    logic [2:0]  cnt_r, cnt_nx_s;
    logic        trap_r, trap_nx_s;
    logic [1:0]  cause_r, cause_nx_s;
    ctrl_t       out_r;

    logic        last_s;
    logic        funct_ok_s;
    logic        addsub_s;
    logic [2:0]  alu_funct_s;
    logic        unused_s;

    // Moore decode of a state; last = final counted cycle of that state,
    // trap = overflow already captured for the coming write-back.
    function automatic ctrl_t decode(input state_t st, input logic last,
                                     input logic trap, input logic [2:0] alu_r);
        ctrl_t c;
        c = '0;
        case (st)
            S_RESET: begin
                c.wreg    = 1'b1;
                c.regdst  = 2'b11;
                c.wdata   = 2'b11;
                c.rst_out = 1'b1;
            end
            S_FETCH: begin
                c.srcb = 2'b01;
                c.alu  = 3'b001;
                c.wpc  = last;
                c.wir  = last;
            end
            S_DECODE: begin
                c.wa   = 1'b1;
                c.wb   = 1'b1;
                c.walu = 1'b1;
                c.srcb = 2'b11;
                c.alu  = 3'b001;
            end
            S_EXEC_R: begin
                c.srca = 1'b1;
                c.alu  = alu_r;
                c.walu = 1'b1;
            end
            S_WB_R: begin
                c.wreg   = ~trap;
                c.regdst = 2'b01;
            end
            S_EXEC_I: begin
                c.srca = 1'b1;
                c.srcb = 2'b10;
                c.alu  = 3'b001;
                c.walu = 1'b1;
            end
            S_WB_I: begin
                c.wreg = ~trap;
            end
            S_BRANCH: begin
                c.srca  = 1'b1;
                c.alu   = 3'b111;
                c.pcsrc = 2'b01;
            end
            S_JUMP: begin
                c.pcsrc = 2'b10;
                c.wpc   = 1'b1;
            end
            S_MEM_ADDR: begin
                c.srca = 1'b1;
                c.srcb = 2'b10;
                c.alu  = 3'b001;
                c.walu = 1'b1;
            end
            S_MEM_RD: begin
                c.maddr = 1'b1;
                c.wmdr  = last;
            end
            S_MEM_WB: begin
                c.wreg  = 1'b1;
                c.wdata = 2'b01;
            end
            S_MEM_WR: begin
                c.maddr = 1'b1;
                c.wmem  = 1'b1;
            end
            S_EXC: begin
                c.wepc  = 1'b1;
                c.srcb  = 2'b01;
                c.alu   = 3'b010;
                c.wpc   = 1'b1;
                c.pcsrc = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // LT needs no control action (ALUOut already holds the slt result).
    assign unused_s = ^{LT, Instruction_15_0[15:6]};
    assign last_s   = (cnt_r == WAIT_C);

    // funct decode: validity, add/sub overflow class and ALU operation.
    always_comb begin
        funct_ok_s  = 1'b1;
        addsub_s    = 1'b0;
        alu_funct_s = 3'b001;
        case (Instruction_15_0[5:0])
            FN_ADD:  addsub_s = 1'b1;
            FN_SUB: begin
                addsub_s    = 1'b1;
                alu_funct_s = 3'b010;
            end
            FN_AND:  alu_funct_s = 3'b011;
            FN_SLT:  alu_funct_s = 3'b111;
            default: funct_ok_s  = 1'b0;
        endcase
    end

    // Next-state, captured-overflow and trap-cause logic.
    always_comb begin
        state_nx_s = state_r;
        trap_nx_s  = trap_r;
        cause_nx_s = cause_r;
        case (state_r)
            S_RESET:  state_nx_s = S_FETCH;
            S_FETCH:  state_nx_s = last_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((Instruction_31_26 == OP_R) && funct_ok_s) begin
                    state_nx_s = S_EXEC_R;
                end else if (Instruction_31_26 == OP_ADDI) begin
                    state_nx_s = S_EXEC_I;
                end else if ((Instruction_31_26 == OP_BEQ) || (Instruction_31_26 == OP_BNE)) begin
                    state_nx_s = S_BRANCH;
                end else if ((Instruction_31_26 == OP_LW) || (Instruction_31_26 == OP_SW)) begin
                    state_nx_s = S_MEM_ADDR;
                end else if (Instruction_31_26 == OP_J) begin
                    state_nx_s = S_JUMP;
                end else if (EXC_ENABLE) begin
                    state_nx_s = S_EXC;
                    cause_nx_s = 2'b01;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_EXEC_R: begin
                state_nx_s = S_WB_R;
                trap_nx_s  = EXC_ENABLE & addsub_s & Overflow;
            end
            S_EXEC_I: begin
                state_nx_s = S_WB_I;
                trap_nx_s  = EXC_ENABLE & Overflow;
            end
            S_WB_R, S_WB_I: begin
                if (trap_r) begin
                    state_nx_s = S_EXC;
                    cause_nx_s = 2'b10;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_MEM_ADDR: state_nx_s = (Instruction_31_26 == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_nx_s = last_s ? S_MEM_WB : S_MEM_RD;
            S_BRANCH, S_JUMP, S_MEM_WB, S_MEM_WR, S_EXC: state_nx_s = S_FETCH;
            default:    state_nx_s = S_RESET;
        endcase
        // Counter clears on every state change and saturates at MEM_WAIT.
        if (state_nx_s != state_r) begin
            cnt_nx_s = 3'd0;
        end else if (last_s) begin
            cnt_nx_s = cnt_r;
        end else begin
            cnt_nx_s = cnt_r + 3'd1;
        end
    end

    // State, counter, cause and registered output decode of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_RESET;
            cnt_r   <= 3'd0;
            trap_r  <= 1'b0;
            cause_r <= 2'b00;
            out_r   <= decode(S_RESET, 1'b0, 1'b0, 3'b001);
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            trap_r  <= trap_nx_s;
            cause_r <= cause_nx_s;
            out_r   <= decode(state_nx_s, (cnt_nx_s == WAIT_C), trap_nx_s, alu_funct_s);
        end
    end

    // Branch write is the single Mealy term: taken depends on this cycle's Zero.
    assign WritePC = out_r.wpc |
                     ((state_r == S_BRANCH) &&
                      ((Instruction_31_26 == OP_BNE) ? ~Zero : Zero));

    assign WriteA           = out_r.wa;
    assign WriteB           = out_r.wb;
    assign WriteALUOut      = out_r.walu;
    assign WriteMDR         = out_r.wmdr;
    assign WriteMem         = out_r.wmem;
    assign WriteInstruction = out_r.wir;
    assign WriteReg         = out_r.wreg;
    assign WriteEPC         = out_r.wepc;
    assign memAddrCtrl      = out_r.maddr;
    assign ALUSrcACtrl      = out_r.srca;
    assign ALUSrcBCtrl      = out_r.srcb;
    assign PCSrcCtrl        = out_r.pcsrc;
    assign WriteRegCtrl     = out_r.regdst;
    assign WriteDataCtrl    = out_r.wdata;
    assign ALUCtrl          = out_r.alu;
    assign resetOut         = out_r.rst_out;
    assign ExcCause         = cause_r;
    assign ExcVector        = EXC_VECTOR;

endmodule
